// File: rtl/except_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : except_arbiter_pkg
//  Purpose  : ExcCodes, M-stage exception flag indices and FSM encoding.
//  Revision : 1.0
// ============================================================================
package except_arbiter_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Bit positions inside m_exc = {adel_if, ri, syscall, brk, ov, adel_d, ades}
    localparam int EXC_FLAGS   = 7;
    localparam int EXB_ADEL_IF = 6;
    localparam int EXB_RI      = 5;
    localparam int EXB_SYS     = 4;
    localparam int EXB_BRK     = 3;
    localparam int EXB_OV      = 2;
    localparam int EXB_ADEL_D  = 1;
    localparam int EXB_ADES    = 0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_ds);
        return in_ds ? (pc - 32'd4) : pc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/except_arbiter_int_sync.sv
`default_nettype none
// ============================================================================
//  Module   : except_arbiter_int_sync
//  Purpose  : SYNC_STAGES-deep flop synchroniser for external interrupt lines.
//  Revision : 1.0
// ============================================================================
module except_arbiter_int_sync #(
    parameter int NUM_HW_INT  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_HW_INT-1:0] i_async,
    output logic [NUM_HW_INT-1:0] o_sync
);

    logic [NUM_HW_INT-1:0] r_stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_stage[s] <= '0;
            end
        end else begin
            r_stage[0] <= i_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_stage[s] <= r_stage[s-1];
            end
        end
    end

    assign o_sync = r_stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/except_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : except_arbiter
//  Purpose  : Registered M-stage exception/interrupt commit unit with bus drain.
//  Revision : 1.0
// ============================================================================
module except_arbiter
    import except_arbiter_pkg::*;
#(
    parameter int          NUM_HW_INT  = 6,
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_HW_INT-1:0] i_ext_int,
    input  logic [31:0]           i_cp0_status,
    input  logic [31:0]           i_cp0_cause,
    input  logic [31:0]           i_cp0_epc,
    input  logic                  i_m_valid,
    input  logic [31:0]           i_m_pc,
    input  logic                  i_m_in_ds,
    input  logic [EXC_FLAGS-1:0]  i_m_exc,
    input  logic                  i_m_eret,
    input  logic [31:0]           i_m_data_addr,
    input  logic                  i_mem_busy,
    output logic                  o_stall_m,
    output logic                  o_flush,
    output logic [31:0]           o_redirect_pc,
    output logic                  o_exc_we,
    output logic [4:0]            o_exc_code,
    output logic [31:0]           o_exc_epc,
    output logic                  o_exc_bd,
    output logic                  o_badvaddr_we,
    output logic [31:0]           o_badvaddr,
    output logic                  o_eret_commit
);

    logic [NUM_HW_INT-1:0] w_int_sync;
    logic [5:0]            w_hw6;
    logic [7:0]            w_pending;
    logic                  w_int_req;
    logic                  w_event;
    logic [4:0]            w_code;
    logic                  w_badv_we;
    logic [31:0]           w_badv;
    logic                  w_is_eret;
    logic [1:0]            r_state;
    logic [1:0]            w_next;

    logic [4:0]            r_code;
    logic [31:0]           r_epc;
    logic                  r_bd;
    logic                  r_badv_we;
    logic [31:0]           r_badv;
    logic                  r_eret;
    logic [31:0]           r_target;

    logic                  w_unused;
    assign w_unused = &{1'b0, i_cp0_status[31:16], i_cp0_status[7:2],
                        i_cp0_cause[31:10], i_cp0_cause[7:0]};

    except_arbiter_int_sync #(
        .NUM_HW_INT  (NUM_HW_INT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (i_ext_int),
        .o_sync  (w_int_sync)
    );

    always_comb begin
        w_hw6                   = '0;
        w_hw6[NUM_HW_INT-1:0]   = w_int_sync;
    end

    // IM[7:0] lines up with {HW[5:0], SW[1:0]}
    assign w_pending = i_cp0_status[15:8] & {w_hw6, i_cp0_cause[9:8]};
    assign w_int_req = (|w_pending) & i_cp0_status[0] & ~i_cp0_status[1];

    assign w_event = (r_state == ST_IDLE) & i_m_valid &
                     (w_int_req | (|i_m_exc) | i_m_eret);

    always_comb begin
        w_code    = EXC_INT;
        w_badv_we = 1'b0;
        w_badv    = '0;
        w_is_eret = 1'b0;
        if (w_int_req) begin
            w_code = EXC_INT;
        end else if (i_m_exc[EXB_ADEL_IF]) begin
            w_code    = EXC_ADEL;
            w_badv_we = 1'b1;
            w_badv    = i_m_pc;
        end else if (i_m_exc[EXB_RI]) begin
            w_code = EXC_RI;
        end else if (i_m_exc[EXB_SYS]) begin
            w_code = EXC_SYS;
        end else if (i_m_exc[EXB_BRK]) begin
            w_code = EXC_BP;
        end else if (i_m_exc[EXB_OV]) begin
            w_code = EXC_OV;
        end else if (i_m_exc[EXB_ADEL_D]) begin
            w_code    = EXC_ADEL;
            w_badv_we = 1'b1;
            w_badv    = i_m_data_addr;
        end else if (i_m_exc[EXB_ADES]) begin
            w_code    = EXC_ADES;
            w_badv_we = 1'b1;
            w_badv    = i_m_data_addr;
        end else begin
            w_is_eret = i_m_eret;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_event) w_next = i_mem_busy ? ST_DRAIN : ST_COMMIT;
            ST_DRAIN:  if (!i_mem_busy) w_next = ST_COMMIT;
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Everything needed for the commit is captured once, at detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code    <= '0;
            r_epc     <= '0;
            r_bd      <= 1'b0;
            r_badv_we <= 1'b0;
            r_badv    <= '0;
            r_eret    <= 1'b0;
            r_target  <= '0;
        end else if (w_event) begin
            r_code    <= w_code;
            r_epc     <= epc_of(i_m_pc, i_m_in_ds);
            r_bd      <= i_m_in_ds;
            r_badv_we <= w_badv_we;
            r_badv    <= w_badv;
            r_eret    <= w_is_eret;
            r_target  <= w_is_eret ? i_cp0_epc : EXC_VECTOR;
        end
    end

    always_comb begin
        o_stall_m     = rst_n & (w_event | (r_state == ST_DRAIN));
        o_flush       = 1'b0;
        o_redirect_pc = '0;
        o_exc_we      = 1'b0;
        o_exc_code    = '0;
        o_exc_epc     = '0;
        o_exc_bd      = 1'b0;
        o_badvaddr_we = 1'b0;
        o_badvaddr    = '0;
        o_eret_commit = 1'b0;
        if (r_state == ST_COMMIT) begin
            o_flush       = 1'b1;
            o_redirect_pc = r_target;
            if (r_eret) begin
                o_eret_commit = 1'b1;
            end else begin
                o_exc_we      = 1'b1;
                o_exc_code    = r_code;
                o_exc_epc     = r_epc;
                o_exc_bd      = r_bd;
                o_badvaddr_we = r_badv_we;
                o_badvaddr    = r_badv;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_except_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_except_arbiter
//  Purpose  : Scoreboard bench for except_arbiter with a priority-table model.
//  Revision : 1.0
// ============================================================================
module tb_except_arbiter;

    localparam int          SYNC = 2;
    localparam logic [31:0] VEC  = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  ext_int;
    logic [31:0] cp0_status, cp0_cause, cp0_epc;
    logic        m_valid, m_in_ds, m_eret, mem_busy;
    logic [31:0] m_pc, m_data_addr;
    logic [6:0]  m_exc;

    logic        o_stall_m, o_flush, o_exc_we, o_exc_bd, o_badvaddr_we, o_eret_commit;
    logic [31:0] o_redirect_pc, o_exc_epc, o_badvaddr;
    logic [4:0]  o_exc_code;

    typedef struct {
        int          cyc;
        bit          eret;
        bit [4:0]    code;
        bit [31:0]   epc;
        bit          bd;
        bit          bw;
        bit [31:0]   badv;
        bit [31:0]   target;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    except_arbiter #(
        .NUM_HW_INT  (6),
        .EXC_VECTOR  (VEC),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ext_int     (ext_int),
        .i_cp0_status  (cp0_status),
        .i_cp0_cause   (cp0_cause),
        .i_cp0_epc     (cp0_epc),
        .i_m_valid     (m_valid),
        .i_m_pc        (m_pc),
        .i_m_in_ds     (m_in_ds),
        .i_m_exc       (m_exc),
        .i_m_eret      (m_eret),
        .i_m_data_addr (m_data_addr),
        .i_mem_busy    (mem_busy),
        .o_stall_m     (o_stall_m),
        .o_flush       (o_flush),
        .o_redirect_pc (o_redirect_pc),
        .o_exc_we      (o_exc_we),
        .o_exc_code    (o_exc_code),
        .o_exc_epc     (o_exc_epc),
        .o_exc_bd      (o_exc_bd),
        .o_badvaddr_we (o_badvaddr_we),
        .o_badvaddr    (o_badvaddr),
        .o_eret_commit (o_eret_commit)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Architectural reference: priority list walked from highest to lowest
    function automatic bit model(output exp_t e);
        logic [7:0] pend;
        bit         intr;
        e      = '{default: 0};
        pend   = cp0_status[15:8] & {ext_int, cp0_cause[9:8]};
        intr   = (pend != 8'd0) && cp0_status[0] && !cp0_status[1];
        e.epc  = m_in_ds ? m_pc - 32'd4 : m_pc;
        e.bd   = m_in_ds;
        e.target = VEC;
        if (!m_valid) return 1'b0;
        if (intr) begin
            e.code = 5'd0;
            return 1'b1;
        end
        for (int i = 0; i < 7; i++) begin
            if (m_exc[6-i]) begin
                case (i)
                    0: begin e.code = 5'd4;  e.bw = 1'b1; e.badv = m_pc; end
                    1: e.code = 5'd10;
                    2: e.code = 5'd8;
                    3: e.code = 5'd9;
                    4: e.code = 5'd12;
                    5: begin e.code = 5'd4;  e.bw = 1'b1; e.badv = m_data_addr; end
                    default: begin e.code = 5'd5; e.bw = 1'b1; e.badv = m_data_addr; end
                endcase
                return 1'b1;
            end
        end
        if (m_eret) begin
            e.eret   = 1'b1;
            e.target = cp0_epc;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic set_env(input logic [5:0] ext, input logic [31:0] st, input logic [31:0] ca);
        ext_int    = ext;
        cp0_status = st;
        cp0_cause  = ca;
        m_valid    = 1'b0;
        mem_busy   = 1'b0;
        repeat (SYNC + 1) tick();
    endtask

    task automatic junk();
        m_valid     = 1'($urandom);
        m_pc        = $urandom;
        m_in_ds     = 1'($urandom);
        m_exc       = 7'($urandom);
        m_eret      = 1'($urandom);
        m_data_addr = $urandom;
        cp0_epc     = $urandom;
    endtask

    // One M-stage presentation; k = cycles mem_busy stays high from detection
    task automatic txn(input bit v, input logic [31:0] pc, input bit ds, input logic [6:0] exc,
                       input bit er, input logic [31:0] da, input logic [31:0] epc_in, input int k);
        exp_t e;
        bit   ev;
        m_valid = v; m_pc = pc; m_in_ds = ds; m_exc = exc; m_eret = er;
        m_data_addr = da; cp0_epc = epc_in; mem_busy = (k > 0);
        ev = model(e);
        if (ev) begin
            e.cyc = cyc + k + 1;
            q.push_back(e);
        end
        @(negedge clk);
        chk("stall_detect", {31'b0, o_stall_m}, {31'b0, ev});
        if (ev) begin
            for (int j = 1; j <= k; j++) begin
                tick();
                junk();
                mem_busy = (j < k);
                @(negedge clk);
                chk("stall_drain", {31'b0, o_stall_m}, 32'd1);
            end
            tick();
            junk();
            m_valid  = 1'b1;
            mem_busy = 1'b0;
            @(negedge clk);
            chk("stall_commit", {31'b0, o_stall_m}, 32'd0);
        end
        tick();
        m_valid  = 1'b0;
        mem_busy = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            chk("reset_outputs", {31'b0, |{o_stall_m, o_flush, o_exc_we, o_badvaddr_we, o_eret_commit,
                                           o_redirect_pc, o_exc_code, o_exc_epc, o_exc_bd, o_badvaddr}}, 32'd0);
        end else if (o_flush) begin
            if (q.size() == 0) begin
                chk("unexpected_flush", {31'b0, o_flush}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("commit_cycle", cyc, e.cyc);
                chk("redirect_pc", o_redirect_pc, e.target);
                chk("exc_we", {31'b0, o_exc_we}, {31'b0, !e.eret});
                chk("eret_commit", {31'b0, o_eret_commit}, {31'b0, e.eret});
                chk("badvaddr_we", {31'b0, o_badvaddr_we}, {31'b0, e.bw});
                if (!e.eret) begin
                    chk("exc_code", {27'b0, o_exc_code}, {27'b0, e.code});
                    chk("exc_epc", o_exc_epc, e.epc);
                    chk("exc_bd", {31'b0, o_exc_bd}, {31'b0, e.bd});
                    if (e.bw) chk("badvaddr", o_badvaddr, e.badv);
                end
            end
        end else begin
            chk("idle_strobes", {29'b0, o_exc_we, o_badvaddr_we, o_eret_commit}, 32'd0);
            chk("idle_data", o_redirect_pc | o_exc_epc | o_badvaddr | {27'b0, o_exc_code} | {31'b0, o_exc_bd}, 32'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; ext_int = '0; cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
        m_valid = 1'b0; m_pc = '0; m_in_ds = 1'b0; m_exc = '0; m_eret = 1'b0;
        m_data_addr = '0; mem_busy = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        set_env(6'd0, 32'd0, 32'd0);

        // syscall, no drain
        txn(1'b1, 32'hBFC00100, 1'b0, 7'b0010000, 1'b0, 32'h0, 32'h0, 0);
        tick();
        // ades with three busy cycles
        txn(1'b1, 32'hBFC00140, 1'b0, 7'b0000001, 1'b0, 32'h80000003, 32'h0, 3);
        tick();
        // ri + ov + adel_d in a delay slot
        txn(1'b1, 32'hBFC00204, 1'b1, 7'b0100110, 1'b0, 32'h00001001, 32'h0, 0);
        tick();
        // ERET
        txn(1'b1, 32'hBFC00300, 1'b0, 7'b0, 1'b1, 32'h0, 32'hBFC00500, 0);
        tick();

        // ext_int[2] with IM[4], IE=1, EXL=0: Int after SYNC cycles
        begin
            exp_t e;
            set_env(6'd0, 32'h0000_1001, 32'd0);
            ext_int = 6'b000100; m_valid = 1'b1; m_pc = 32'hBFC00400; m_in_ds = 1'b0;
            m_exc = '0; m_eret = 1'b0;
            e = '{default: 0};
            e.cyc = cyc + SYNC + 1; e.code = 5'd0; e.epc = 32'hBFC00400; e.target = VEC;
            q.push_back(e);
            for (int s = 0; s < SYNC; s++) begin
                @(negedge clk);
                chk("int_not_yet", {31'b0, o_stall_m}, 32'd0);
                tick();
            end
            @(negedge clk);
            chk("int_detect", {31'b0, o_stall_m}, 32'd1);
            tick();
            m_valid = 1'b0;
            tick();
            ext_int = '0;
        end
        // same with EXL=1: nothing
        set_env(6'd0, 32'h0000_1003, 32'd0);
        ext_int = 6'b000100; m_valid = 1'b1; m_pc = 32'hBFC00400;
        repeat (SYNC + 3) begin
            @(negedge clk);
            chk("int_masked_exl", {31'b0, o_stall_m}, 32'd0);
            tick();
        end
        m_valid = 1'b0;
        set_env(6'd0, 32'd0, 32'd0);

        // reset during DRAIN aborts without a commit
        m_valid = 1'b1; m_pc = 32'hBFC00600; m_exc = 7'b0000001; m_data_addr = 32'h3; mem_busy = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("reset_stall", {31'b0, o_stall_m}, 32'd0);
        chk("reset_flush", {31'b0, o_flush | o_exc_we | o_badvaddr_we}, 32'd0);
        m_valid = 1'b0; m_exc = '0;
        tick();
        tick();
        rst_n = 1'b1;
        mem_busy = 1'b0;
        repeat (5) tick();

        // randomized traffic
        repeat (150) begin
            set_env(6'($urandom) & 6'($urandom), $urandom, $urandom);
            txn(($urandom_range(0, 7) != 0), $urandom, 1'($urandom),
                {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0)},
                ($urandom_range(0, 3) == 0), $urandom, $urandom, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (5) tick();
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/except_arbiter.md
# except_arbiter

Parametrised exception/interrupt arbiter for the MIPS core. It replaces the purely combinational M-stage exception decode with a registered, architecturally ordered commit unit. It synchronises external interrupt lines and prioritises M-stage exceptions per MIPS32 ordering. Before committing, it waits for any outstanding data-bus transaction to drain, then issues one-cycle CP0 update, flush and redirect pulses.

## Interface
- NUM_HW_INT, 6: number of external hardware interrupt lines (1..6), mapped to Cause.IP[2+:NUM_HW_INT].
- EXC_VECTOR, 32'hBFC00380: general exception entry address.
- SYNC_STAGES, 2: flop stages on ext_int (>=2).

- clk  in  1  core clock.
- resetn  in  1  asynchronous, active-low reset.
- ext_int  in  NUM_HW_INT  raw level interrupt requests.
- cp0_status  in  32  Status; uses IM[15:8], EXL[1], IE[0].
- cp0_cause  in  32  Cause; uses IP[9:8] (software).
- cp0_epc  in  32  EPC, ERET target.
- m_valid  in  1  M stage holds a real instruction.
- m_pc  in  32  PC of the M-stage instruction.
- m_in_ds  in  1  M instruction is in a branch delay slot.
- m_exc  in  7  flags {adel_if, ri, syscall, brk, ov, adel_d, ades}.
- m_eret  in  1  M instruction is ERET.
- m_data_addr  in  32  load/store effective address.
- mem_busy  in  1  data-bus transaction outstanding.
- stall_m  out  1  hold M and earlier stages.
- flush  out  1  one-cycle flush of all stages.
- redirect_pc  out  32  next fetch PC, valid with flush.
- exc_we  out  1  CP0 exception update strobe (set EXL, write Cause.ExcCode/BD, EPC).
- exc_code  out  5  ExcCode.
- exc_epc  out  32  EPC value.
- exc_bd  out  1  Cause.BD value.
- badvaddr_we  out  1  BadVAddr write strobe.
- badvaddr  out  32  BadVAddr value.
- eret_commit  out  1  clear EXL strobe.

## Operation
- Interrupt pending: int_req = |(IM & {sync(ext_int) zero-extended to 6, IP[9:8]}) & IE & ~EXL. Only attaches to an M instruction with m_valid=1.
- Priority, highest first, for m_valid=1:
  - Int (0)
  - adel_if (AdEL 4, badvaddr=m_pc)
  - ri (RI 10)
  - syscall (Sys 8)
  - brk (Bp 9)
  - ov (Ov 12)
  - adel_d (AdEL 4, badvaddr=m_data_addr)
  - ades (AdES 5, badvaddr=m_data_addr)
  - eret
- Exceptions other than Int are taken regardless of EXL.
- EPC = m_in_ds ? m_pc-4 : m_pc (mod 2^32); exc_bd = m_in_ds.
- FSM states and transitions:
  - IDLE: on a detected event, latch code/EPC/BD/badvaddr/ERET flag and the target. The target is EXC_VECTOR, or cp0_epc for ERET, sampled at detection. Go to DRAIN if mem_busy, else COMMIT.
  - DRAIN: wait until mem_busy=0, then go to COMMIT.
  - COMMIT: pulse flush; drive redirect_pc from the latched target.
    - For an exception, pulse exc_we, plus badvaddr_we for AdEL/AdES.
    - For ERET, pulse eret_commit.
    - Go to IDLE.
- stall_m=1 in the detection cycle (combinational) and throughout DRAIN; it is 0 in COMMIT.
- Latched values are frozen after detection; input changes during DRAIN are ignored.
- A new event is not accepted in the COMMIT cycle. Flushed M content is invalid in the next cycle anyway.

## Timing
- Reset (async assert, sync-released by the top level): FSM=IDLE, synchroniser flops=0, all outputs 0.
- Reset mid-DRAIN/COMMIT aborts with no pulse.
- Latency with mem_busy=0: event in cycle N, flush/exc_we in N+1.
- Latency with mem_busy: event in cycle N, busy low in cycle N+k, commit in N+k+1.
- Interrupt latency from ext_int edge to int_req: SYNC_STAGES cycles.
- All strobes are exactly one cycle wide and never assert outside COMMIT.
- redirect_pc and exc_* outputs are 0 outside COMMIT.

## Structure
- A shared cpu package holds ExcCode constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV), the m_exc bit indices, and the FSM state encoding.
- One sub-module, int_sync: a parametrised SYNC_STAGES x NUM_HW_INT flop synchroniser with async active-low reset.

## Test plan
- Syscall at m_pc=0xBFC00100, m_in_ds=0, mem_busy=0:
  - stall_m in N.
  - In N+1: flush=1, exc_we=1, exc_code=8, exc_epc=0xBFC00100, redirect_pc=0xBFC00380, badvaddr_we=0.
- ades at m_data_addr=0x80000003 with mem_busy high for 3 cycles:
  - stall_m for 4 cycles.
  - COMMIT on the cycle after busy falls, with exc_code=5, badvaddr=0x80000003.
- Simultaneous ri and ov and adel_d with m_in_ds=1, m_pc=0xBFC00204:
  - exc_code=10, exc_epc=0xBFC00200, exc_bd=1.
- ext_int[2]=1, IM[4]=1, IE=1, EXL=0:
  - Int taken exactly SYNC_STAGES cycles later on the next m_valid instruction.
  - The same stimulus with EXL=1 produces no flush.
- ERET with cp0_epc=0xBFC00500:
  - eret_commit=1, redirect_pc=0xBFC00500, exc_we=0.
- resetn deasserted (driven low) during DRAIN: all outputs go to 0 immediately; no flush follows release.
